// File: rtl/io_register_bank.sv
// IO controller register bank: GPIO synchroniser, edge-capture pending bits, W1C clear, level irq.
// Optional build macro INT_BOTH_EDGES_EN: pending bits capture falling as well as rising edges.
module io_register_bank #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] reg_data_io,
    output logic [DATA_WIDTH-1:0] reg_control,
    output logic [DATA_WIDTH-1:0] reg_interrupt,
    output logic                  irq
);

    typedef enum logic [1:0] {
        ADDR_DATA_IO   = 2'd0,
        ADDR_CONTROL   = 2'd1,
        ADDR_INTERRUPT = 2'd2,
        ADDR_RESERVED  = 2'd3
    } addr_e;

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] hist;
    logic [SYNC_STAGES:0]  prime_q;
    logic [DATA_WIDTH-1:0] edges;
    logic [DATA_WIDTH-1:0] clr;

    assign reg_data_io = sync_q[SYNC_STAGES-1];

    // prime_q tracks how far the first post-reset sample has travelled; edges are only
    // trusted once both reg_data_io and hist hold real samples, so pins already high at
    // reset release never look like an edge.
    always_comb begin
        // NOTE: default first so every path assigns clr and no latch is inferred.
        clr = '0;
        if (write && addr_e'(write_addr) == ADDR_INTERRUPT)
            clr = write_data;
    end

`ifdef INT_BOTH_EDGES_EN
    assign edges = prime_q[SYNC_STAGES] ? (reg_data_io ^ hist) : '0;
`else
    assign edges = prime_q[SYNC_STAGES] ? (reg_data_io & ~hist) : '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the synchroniser is a chain of flops, not a RAM, so it is reset too.
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            hist          <= '0;
            prime_q       <= '0;
            gpio_out      <= '0;
            reg_control   <= '0;
            reg_interrupt <= '0;
            irq           <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            hist    <= reg_data_io;
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};

            // A new edge beats a simultaneous clear so it is never lost.
            reg_interrupt <= (reg_interrupt & ~clr) | edges;
            irq           <= |(reg_interrupt & reg_control);

            if (write) begin
                case (addr_e'(write_addr))
                    ADDR_DATA_IO:   gpio_out    <= write_data;
                    ADDR_CONTROL:   reg_control <= write_data;
                    ADDR_INTERRUPT: ;
                    ADDR_RESERVED:  ;
                    default:        ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_register_bank.sv
// Self-checking bench for io_register_bank: write-path vector table plus interrupt sequences.
module tb_io_register_bank;

    localparam int DW   = 32;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic [1:0]    write_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] gpio_in;
    logic [DW-1:0] gpio_out;
    logic [DW-1:0] reg_data_io;
    logic [DW-1:0] reg_control;
    logic [DW-1:0] reg_interrupt;
    logic          irq;

    int errors = 0;
    int checks = 0;

    io_register_bank #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .reset         (reset),
        .write         (write),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .reg_data_io   (reg_data_io),
        .reg_control   (reg_control),
        .reg_interrupt (reg_interrupt),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [1:0]    addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_gpio_out;
        logic [DW-1:0] exp_control;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [DW-1:0] data);
        write      = 1'b1;
        write_addr = addr;
        write_data = data;
        step();
        write      = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_fall;
`ifdef INT_BOTH_EDGES_EN
        exp_fall = 32'h1;
`else
        exp_fall = 32'h0;
`endif
        vecs[0] = '{1'b1, 2'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h0};
        vecs[1] = '{1'b1, 2'd3, 32'h0000_1234, 32'hA5A5_0F0F, 32'h0};
        vecs[2] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 32'h0};
        vecs[3] = '{1'b1, 2'd1, 32'h0000_F00D, 32'hA5A5_0F0F, 32'h0000_F00D};
        vecs[4] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 32'h0000_F00D};
        vecs[5] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 32'h0000_F00D};
        vecs[6] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0,         32'h0000_F00D};
        vecs[7] = '{1'b1, 2'd1, 32'h0000_0001, 32'h0,         32'h0000_0001};

        reset = 1'b1; write = 1'b0; write_addr = 2'd0; write_data = '0;
        gpio_in = 32'hFFFF_FFFF;
        step(3);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_data_io", reg_data_io, 32'h0);
        check("rst_control", reg_control, 32'h0);
        check("rst_interrupt", reg_interrupt, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Inputs high at reset release: visible after SYNC cycles, never an edge.
        reset = 1'b0;
        step(SYNC - 1);
        check("sync_not_yet", reg_data_io, 32'h0);
        step();
        check("sync_arrive", reg_data_io, 32'hFFFF_FFFF);
        step(4);
        check("prime_no_pending", reg_interrupt, 32'h0);
        check("prime_no_irq", {31'b0, irq}, 32'h0);

        // Drop all inputs and clear anything a both-edges build captured.
        gpio_in = 32'h0;
        step(SYNC + 2);
        bus_write(2'd2, 32'hFFFF_FFFF);
        check("fall_cleared", reg_interrupt, 32'h0);
        check("data_io_low", reg_data_io, 32'h0);

        for (int i = 0; i < 8; i++) begin
            write      = vecs[i].wr;
            write_addr = vecs[i].addr;
            write_data = vecs[i].data;
            step();
            write = 1'b0;
            check($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_gpio_out);
            check($sformatf("vec%0d_control", i), reg_control, vecs[i].exp_control);
            check($sformatf("vec%0d_interrupt", i), reg_interrupt, 32'h0);
        end

        // Bit0 rising edge with enable set.
        gpio_in = 32'h1;
        step(SYNC);
        check("edge_not_yet", reg_interrupt, 32'h0);
        step();
        check("edge_pending", reg_interrupt, 32'h1);
        check("edge_irq_lag", {31'b0, irq}, 32'h0);
        step();
        check("edge_irq", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h1);
        check("w1c_cleared", reg_interrupt, 32'h0);
        check("w1c_irq_lag", {31'b0, irq}, 32'h1);
        step();
        check("w1c_irq_low", {31'b0, irq}, 32'h0);

        // Bit3 edge lands in the same cycle as its W1C: set wins.
        gpio_in = 32'h9;
        step(SYNC);
        check("race_before", reg_interrupt, 32'h0);
        bus_write(2'd2, 32'h8);
        check("race_set_wins", reg_interrupt, 32'h8);
        bus_write(2'd2, 32'h8);
        check("race_cleared", reg_interrupt, 32'h0);

        // Bit5 edge with mask clear: pending but no irq until enabled.
        bus_write(2'd1, 32'h0);
        gpio_in = 32'h29;
        step(SYNC + 1);
        check("mask_pending", reg_interrupt, 32'h20);
        step();
        check("mask_irq_off", {31'b0, irq}, 32'h0);
        bus_write(2'd1, 32'h20);
        check("mask_control", reg_control, 32'h20);
        check("mask_irq_lag", {31'b0, irq}, 32'h0);
        step();
        check("mask_irq_on", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h20);
        step();
        check("mask_irq_clear", {31'b0, irq}, 32'h0);

        // Bit0 falling edge: captured only in a both-edges build.
        gpio_in = 32'h28;
        step(SYNC + 2);
        check("falling_edge", reg_interrupt, exp_fall);
        bus_write(2'd2, 32'hFFFF_FFFF);

        // Reset mid-operation discards everything, then re-primes.
        bus_write(2'd0, 32'h0000_DEAD);
        bus_write(2'd1, 32'hFFFF_FFFF);
        reset = 1'b1;
        step();
        check("mid_rst_gpio_out", gpio_out, 32'h0);
        check("mid_rst_control", reg_control, 32'h0);
        check("mid_rst_data_io", reg_data_io, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        step(SYNC + 4);
        check("reprime_data_io", reg_data_io, 32'h28);
        check("reprime_pending", reg_interrupt, 32'h0);
        check("reprime_irq", {31'b0, irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
